seq_load_scheduler: RTL and testbench

SEQ_LOAD_SCHEDULER -- requirements
Module: seq_load_scheduler

---
 rtl/seq_load_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_seq_load_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_load_scheduler.sv
// ---------------------------------------------------------------------------
// seq_load_scheduler
//
// Loads a query sequence and then a database sequence from a byte-wide host
// stream, holds both stable, and steps an anti-diagonal index for a processing
// unit (PU) array until every diagonal has been handled.
//
// Ports
//   clk          : sole clock, rising-edge active
//   rst          : asynchronous, active-high reset
//   start        : single-cycle request to begin a new load (IDLE/DONE only)
//   data_in      : packed letters from the host, lowest letter in the low bits
//   data_valid   : data_in is valid this cycle
//   data_ready   : block accepts data_in this cycle (load states only)
//   query_seq    : loaded query sequence, letter i at bits [2i+1:2i]
//   db_seq       : loaded database sequence, same packing
//   load_done    : both sequences loaded and held stable
//   diag_advance : PU array finished the current diagonal
//   diag_idx     : current anti-diagonal index
//   diag_valid   : diag_idx is meaningful for the PU array
//   align_done   : all diagonals processed
// ---------------------------------------------------------------------------
module seq_load_scheduler #(
    parameter int SEQ_LENGTH    = 32,
    parameter int LETTER_WIDTH  = 2,
    parameter int INPUT_WIDTH   = 8,
    parameter int NUM_DIAGONALS = 31
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [INPUT_WIDTH-1:0]             data_in,
    input  logic                               data_valid,
    output logic                               data_ready,
    output logic [SEQ_LENGTH*LETTER_WIDTH-1:0] query_seq,
    output logic [SEQ_LENGTH*LETTER_WIDTH-1:0] db_seq,
    output logic                               load_done,
    input  logic                               diag_advance,
    output logic [4:0]                         diag_idx,
    output logic                               diag_valid,
    output logic                               align_done
);

    // Derived geometry: one sequence is SEQ_BITS wide and arrives in
    // BYTES_PER_SEQ transfers, so the byte counter needs CNT_W bits.
    localparam int SEQ_BITS      = SEQ_LENGTH * LETTER_WIDTH;
    localparam int BYTES_PER_SEQ = SEQ_BITS / INPUT_WIDTH;
    localparam int CNT_W         = (BYTES_PER_SEQ > 1) ? $clog2(BYTES_PER_SEQ) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BYTES_PER_SEQ - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [4:0]       DIAG_LAST = 5'(NUM_DIAGONALS - 1);
    localparam logic [4:0]       DIAG_ZERO = 5'd0;
    localparam logic [4:0]       DIAG_ONE  = 5'd1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_Q  = 3'd1;
    localparam logic [2:0] ST_LOAD_D  = 3'd2;
    localparam logic [2:0] ST_COMPUTE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]          state_r;
    logic [2:0]          state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    logic [SEQ_BITS-1:0] query_r;
    logic [SEQ_BITS-1:0] query_s;
    logic [SEQ_BITS-1:0] db_r;
    logic [SEQ_BITS-1:0] db_s;
    logic [4:0]          diag_r;
    logic [4:0]          diag_s;

    // Writes one host transfer into slot 'slot' of a sequence; every other
    // slot keeps its previous contents.
    function automatic logic [SEQ_BITS-1:0] write_slot(
        input logic [SEQ_BITS-1:0]    seq,
        input logic [CNT_W-1:0]       slot,
        input logic [INPUT_WIDTH-1:0] byte_val
    );
        logic [SEQ_BITS-1:0] result;
        result = seq;
        for (int k = 0; k < BYTES_PER_SEQ; k++) begin
            if (slot == CNT_W'(k)) begin
                result[k*INPUT_WIDTH +: INPUT_WIDTH] = byte_val;
            end else begin
                result[k*INPUT_WIDTH +: INPUT_WIDTH] = seq[k*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
        return result;
    endfunction

    // Next-state and next-datapath logic for the load/compute sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        query_s = query_r;
        db_s    = db_r;
        diag_s  = diag_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                // A new request discards everything from the previous run.
                if (start) begin
                    state_s = ST_LOAD_Q;
                    cnt_s   = CNT_ZERO;
                    query_s = '0;
                    db_s    = '0;
                    diag_s  = DIAG_ZERO;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD_Q: begin
                // data_ready is 1 here, so data_valid alone marks a transfer.
                if (data_valid) begin
                    query_s = write_slot(query_r, cnt_r, data_in);
                    if (cnt_r == CNT_LAST) begin
                        state_s = ST_LOAD_D;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_LOAD_D: begin
                if (data_valid) begin
                    db_s = write_slot(db_r, cnt_r, data_in);
                    if (cnt_r == CNT_LAST) begin
                        state_s = ST_COMPUTE;
                        cnt_s   = CNT_ZERO;
                        diag_s  = DIAG_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_COMPUTE: begin
                // The last diagonal index is held on exit; it never wraps.
                if (diag_advance) begin
                    if (diag_r == DIAG_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        diag_s = diag_r + DIAG_ONE;
                    end
                end else begin
                    diag_s = diag_r;
                end
            end
            default: begin
                // Unreachable encodings fall back to a clean idle state.
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                query_s = '0;
                db_s    = '0;
                diag_s  = DIAG_ZERO;
            end
        endcase
    end

    // State and datapath registers with asynchronous abort on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            query_r <= '0;
            db_r    <= '0;
            diag_r  <= DIAG_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            query_r <= query_s;
            db_r    <= db_s;
            diag_r  <= diag_s;
        end
    end

    // Status outputs are pure decodes of the registered state.
    assign data_ready = (state_r == ST_LOAD_Q) || (state_r == ST_LOAD_D);
    assign load_done  = (state_r == ST_COMPUTE) || (state_r == ST_DONE);
    assign diag_valid = (state_r == ST_COMPUTE);
    assign align_done = (state_r == ST_DONE);
    assign query_seq  = query_r;
    assign db_seq     = db_r;
    assign diag_idx   = diag_r;

endmodule

// File: tb/tb_seq_load_scheduler.sv
// ---------------------------------------------------------------------------
// tb_seq_load_scheduler
//
// Self-checking bench for seq_load_scheduler. A byte-array reference model
// tracks which sequence is being filled and how many bytes have arrived; after
// every clock edge all DUT outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_seq_load_scheduler;

    localparam int NDIAG = 31;
    localparam int P_IDLE = 0;
    localparam int P_LOADQ = 1;
    localparam int P_LOADD = 2;
    localparam int P_COMP = 3;
    localparam int P_DONE = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic [63:0] query_seq;
    logic [63:0] db_seq;
    logic        load_done;
    logic        diag_advance;
    logic [4:0]  diag_idx;
    logic        diag_valid;
    logic        align_done;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int         m_phase;
    int         m_n;
    int         m_diag;
    logic [7:0] mq [8];
    logic [7:0] md [8];

    seq_load_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .query_seq    (query_seq),
        .db_seq       (db_seq),
        .load_done    (load_done),
        .diag_advance (diag_advance),
        .diag_idx     (diag_idx),
        .diag_valid   (diag_valid),
        .align_done   (align_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            mq[k] = 8'h00;
            md[k] = 8'h00;
        end
        m_n    = 0;
        m_diag = 0;
    endtask

    // One rising edge of the reference behaviour.
    task automatic model_step(input logic s, input logic v, input logic [7:0] d, input logic a);
        case (m_phase)
            P_IDLE, P_DONE: begin
                if (s) begin
                    model_clear();
                    m_phase = P_LOADQ;
                end
            end
            P_LOADQ: begin
                if (v) begin
                    mq[m_n] = d;
                    m_n++;
                    if (m_n == 8) begin
                        m_n = 0;
                        m_phase = P_LOADD;
                    end
                end
            end
            P_LOADD: begin
                if (v) begin
                    md[m_n] = d;
                    m_n++;
                    if (m_n == 8) begin
                        m_n = 0;
                        m_diag = 0;
                        m_phase = P_COMP;
                    end
                end
            end
            P_COMP: begin
                if (a) begin
                    if (m_diag == NDIAG - 1) m_phase = P_DONE;
                    else m_diag++;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic check_outputs(input string ctx);
        logic [63:0] eq;
        logic [63:0] ed;
        for (int k = 0; k < 8; k++) begin
            eq[k*8 +: 8] = mq[k];
            ed[k*8 +: 8] = md[k];
        end
        chk({ctx, ".data_ready"}, 64'(data_ready), 64'(m_phase == P_LOADQ || m_phase == P_LOADD));
        chk({ctx, ".load_done"},  64'(load_done),  64'(m_phase == P_COMP || m_phase == P_DONE));
        chk({ctx, ".diag_valid"}, 64'(diag_valid), 64'(m_phase == P_COMP));
        chk({ctx, ".align_done"}, 64'(align_done), 64'(m_phase == P_DONE));
        chk({ctx, ".diag_idx"},   64'(diag_idx),   64'(m_diag));
        chk({ctx, ".query_seq"},  query_seq, eq);
        chk({ctx, ".db_seq"},     db_seq,    ed);
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then compare.
    task automatic tick(input string ctx, input logic s, input logic v,
                        input logic [7:0] d, input logic a);
        start        = s;
        data_valid   = v;
        data_in      = d;
        diag_advance = a;
        @(posedge clk);
        model_step(s, v, d, a);
        #1;
        check_outputs(ctx);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse, checked while asserted and after release.
    task automatic do_reset(input string ctx);
        start = 1'b0; data_valid = 1'b0; diag_advance = 1'b0; data_in = 8'h00;
        #2;
        rst = 1'b1;
        m_phase = P_IDLE;
        model_clear();
        #1;
        check_outputs({ctx, ".async"});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs({ctx, ".released"});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_valid = 1'b0; data_in = 8'h00; diag_advance = 1'b0;
        m_phase = P_IDLE;
        model_clear();
        @(negedge clk);
        do_reset("reset");

        // Back-to-back load of known bytes; start accepted right after reset.
        tick("start0", 1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) tick("loadq", 1'b0, 1'b1, 8'(k), 1'b0);
        for (int k = 0; k < 8; k++) tick("loadd", 1'b0, 1'b1, 8'(8'h10 + k), 1'b0);
        chk("b2b.query_const", query_seq, 64'h0706050403020100);
        chk("b2b.db_const",    db_seq,    64'h1716151413121110);
        chk("b2b.load_done",   64'(load_done), 64'd1);

        // Data and start presented during COMPUTE are ignored.
        for (int k = 0; k < 3; k++) tick("comp_aa", 1'b0, 1'b1, 8'hAA, 1'b0);
        tick("comp_start", 1'b1, 1'b0, 8'h00, 1'b0);

        // 31 advance pulses with random gaps.
        for (int p = 0; p < NDIAG; p++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick("diag_gap", 1'b0, 1'b0, 8'h00, 1'b0);
            tick("diag_adv", 1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("done.align_done", 64'(align_done), 64'd1);
        chk("done.diag_idx",   64'(diag_idx),   64'd30);
        chk("done.diag_valid", 64'(diag_valid), 64'd0);

        // DONE ignores data and advances, then start restarts with cleared data.
        tick("done_aa",  1'b0, 1'b1, 8'hAA, 1'b1);
        tick("restart",  1'b1, 1'b0, 8'h00, 1'b0);
        chk("restart.query_zero", query_seq, 64'h0);
        chk("restart.align_done", 64'(align_done), 64'd0);

        // Stalled load with alternate-cycle data_valid, start poked mid-load.
        for (int k = 0; k < 16; k++) begin
            tick("stall_gap", 1'b0, 1'b0, 8'h00, 1'b0);
            tick("stall_xfer", (k == 10) ? 1'b1 : 1'b0, 1'b1, 8'((k < 8) ? k : 8'h10 + k - 8), 1'b0);
        end
        chk("stall.query_const", query_seq, 64'h0706050403020100);
        chk("stall.db_const",    db_seq,    64'h1716151413121110);

        // Fully random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            tick("random", ($urandom_range(0, 15) == 0), 1'($urandom), 8'($urandom),
                 ($urandom_range(0, 1) == 0));
        end

        // Abort after 5 query bytes, then reload with all ones.
        do_reset("pre_abort");
        tick("abort_start", 1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 5; k++) tick("abort_q", 1'b0, 1'b1, 8'($urandom), 1'b0);
        do_reset("abort");
        tick("ff_start", 1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 16; k++) tick("ff_load", 1'b0, 1'b1, 8'hFF, 1'b0);
        chk("ff.query_ones", query_seq, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ff.db_ones",    db_seq,    64'hFFFF_FFFF_FFFF_FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
